// File: rtl/gmii_rx_framer_pkg.sv
// rtl/gmii_rx_framer_pkg.sv - shared state encoding and constants for the GMII receive framer
package gmii_rx_framer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        DATA     = 3'd2,
        COMMIT   = 3'd3,
        DROP     = 3'd4
    } state_t;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         RXMEM_AW      = 12;

endpackage

// File: rtl/gmii_rx_framer.sv
// rtl/gmii_rx_framer.sv - GMII receive framer into a 4096x16 ring; optional RX_TIMESTAMP_EN
module gmii_rx_framer
    import gmii_rx_framer_pkg::*;
#(
    parameter int MIN_LEN = 14,
    parameter int MAX_LEN = 1522
) (
    input  logic                gmii_rx_clk,
    input  logic                sys_rst,
    input  logic                gmii_rx_dv,
    input  logic [7:0]          gmii_rxd,
    input  logic [RXMEM_AW-1:0] mem_rd_ptr,
    output logic                mem_wr_en,
    output logic [RXMEM_AW-1:0] mem_wr_addr,
    output logic [15:0]         mem_wr_data,
    output logic [RXMEM_AW-1:0] rx_wr_ptr,
    output logic [15:0]         rx_frame_cnt,
    output logic [15:0]         rx_drop_cnt
);

`ifdef RX_TIMESTAMP_EN
    localparam logic [RXMEM_AW-1:0] H = 12'd3;
`else
    localparam logic [RXMEM_AW-1:0] H = 12'd1;
`endif
    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [RXMEM_AW-1:0] r_hdr_addr;
    logic [15:0]         r_len;
    logic [7:0]          r_hi_byte;

    logic                w_wr_en;
    logic [RXMEM_AW-1:0] w_wr_addr;
    logic [15:0]         w_wr_data;
    logic                w_commit;
    logic                w_drop;
    logic                w_sfd;
    logic [RXMEM_AW-1:0] w_free;
    logic [RXMEM_AW-1:0] w_word_off;
    logic                w_fits;

    // Words available ahead of the header before running into the reader; the
    // word currently being completed (byte count odd) lands at offset H + len/2.
    assign w_free     = mem_rd_ptr - r_hdr_addr - 12'd1;
    assign w_word_off = H + r_len[12:1];
    assign w_fits     = (w_word_off < w_free);

`ifdef RX_TIMESTAMP_EN
    logic [31:0] r_ts_cnt;
    logic [31:0] r_ts;
    logic [1:0]  r_commit_step;

    // Free-running cycle counter, snapshot at SFD, and COMMIT sub-step sequencer
    always_ff @(posedge gmii_rx_clk) begin
        if (sys_rst) begin
            r_ts_cnt      <= '0;
            r_ts          <= '0;
            r_commit_step <= '0;
        end else begin
            r_ts_cnt      <= r_ts_cnt + 32'd1;
            if (w_sfd) r_ts <= r_ts_cnt;
            r_commit_step <= (r_state == COMMIT) ? r_commit_step + 2'd1 : 2'd0;
        end
    end
`endif

    // State register
    always_ff @(posedge gmii_rx_clk) begin
        if (sys_rst) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state plus the single memory write and counter events for this cycle
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_wr_addr   = r_hdr_addr;
        w_wr_data   = 16'h0000;
        w_commit    = 1'b0;
        w_drop      = 1'b0;
        w_sfd       = 1'b0;
        case (r_state)
            IDLE: begin
                if (gmii_rx_dv && gmii_rxd == PREAMBLE_BYTE) w_state_nxt = PREAMBLE;
            end
            PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    w_state_nxt = IDLE;
                end else if (gmii_rxd == SFD_BYTE) begin
                    w_state_nxt = DATA;
                    w_sfd       = 1'b1;
                end else if (gmii_rxd != PREAMBLE_BYTE) begin
                    w_state_nxt = IDLE;
                end
            end
            DATA: begin
                if (gmii_rx_dv) begin
                    if (r_len >= MAX_LEN_W) begin
                        w_state_nxt = DROP;
                    end else if (r_len[0]) begin
                        if (!w_fits) begin
                            w_state_nxt = DROP;
                        end else begin
                            w_wr_en   = 1'b1;
                            w_wr_addr = r_hdr_addr + w_word_off;
                            w_wr_data = {r_hi_byte, gmii_rxd};
                        end
                    end
                end else if (r_len < MIN_LEN_W) begin
                    w_state_nxt = IDLE;
                    w_drop      = 1'b1;
                end else if (r_len[0] && !w_fits) begin
                    w_state_nxt = DROP;
                end else begin
                    w_state_nxt = COMMIT;
                    if (r_len[0]) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = r_hdr_addr + w_word_off;
                        w_wr_data = {r_hi_byte, 8'h00};
                    end
                end
            end
            COMMIT: begin
`ifdef RX_TIMESTAMP_EN
                w_wr_en = 1'b1;
                case (r_commit_step)
                    2'd0: begin
                        w_wr_addr = r_hdr_addr + 12'd1;
                        w_wr_data = r_ts[31:16];
                    end
                    2'd1: begin
                        w_wr_addr = r_hdr_addr + 12'd2;
                        w_wr_data = r_ts[15:0];
                    end
                    default: begin
                        w_wr_data   = r_len;
                        w_commit    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                endcase
`else
                w_wr_en     = 1'b1;
                w_wr_data   = r_len;
                w_commit    = 1'b1;
                w_state_nxt = IDLE;
`endif
            end
            DROP: begin
                if (!gmii_rx_dv) begin
                    w_state_nxt = IDLE;
                    w_drop      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Registered write port, byte packer, frame bookkeeping and saturating counters
    always_ff @(posedge gmii_rx_clk) begin
        if (sys_rst) begin
            mem_wr_en    <= 1'b0;
            mem_wr_addr  <= '0;
            mem_wr_data  <= '0;
            rx_wr_ptr    <= '0;
            rx_frame_cnt <= '0;
            rx_drop_cnt  <= '0;
            r_hdr_addr   <= '0;
            r_len        <= '0;
            r_hi_byte    <= '0;
        end else begin
            mem_wr_en <= w_wr_en;
            if (w_wr_en) begin
                mem_wr_addr <= w_wr_addr;
                mem_wr_data <= w_wr_data;
            end
            if (w_sfd) begin
                r_hdr_addr <= rx_wr_ptr;
                r_len      <= '0;
            end else if (r_state == DATA && gmii_rx_dv && w_state_nxt == DATA) begin
                r_len <= r_len + 16'd1;
                if (!r_len[0]) r_hi_byte <= gmii_rxd;
            end
            if (w_commit) begin
                rx_wr_ptr <= r_hdr_addr + H + r_len[12:1] + {11'd0, r_len[0]};
                if (rx_frame_cnt != 16'hFFFF) rx_frame_cnt <= rx_frame_cnt + 16'd1;
            end
            if (w_drop && rx_drop_cnt != 16'hFFFF) rx_drop_cnt <= rx_drop_cnt + 16'd1;
        end
    end

endmodule
